// File: rtl/fifo_merge_ms_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ms_pkg
//   Shared constants and types for the two-stream merging FIFO.
//   - N_STREAMS  : number of producer streams that are merged
//   - DEF_DATA_W : default payload width per stream
//   - DEF_DEPTH  : default entries per stream queue
//   - TAG_BIT    : bit index of the stream id in the default output word
//   - stream_id_t: type that names one stream
// -----------------------------------------------------------------------------
package fifo_ms_pkg;

    localparam int N_STREAMS  = 2;
    localparam int DEF_DATA_W = 7;
    localparam int DEF_DEPTH  = 4;
    localparam int TAG_BIT    = DEF_DATA_W;

    typedef logic [$clog2(N_STREAMS)-1:0] stream_id_t;

endpackage

// File: rtl/fifo_merge_ms_if.sv
// -----------------------------------------------------------------------------
// fifo_merge_ms_if
//   Bus bundle of the merging FIFO.
//   - wr[1:0]          : per-stream write strobes
//   - datain0/datain1  : per-stream payloads
//   - full[1:0]        : per-stream queue full flags
//   - rd               : pop one word from the merged output
//   - empty            : both queues empty
//   - dataout          : registered tagged word {stream_id, payload}
//   Modports: master = producers/consumer, slave = the FIFO.
// -----------------------------------------------------------------------------
interface fifo_merge_ms_if
    import fifo_ms_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [N_STREAMS-1:0] wr;
    logic [DATA_W-1:0]    datain0;
    logic [DATA_W-1:0]    datain1;
    logic [N_STREAMS-1:0] full;
    logic                 rd;
    logic                 empty;
    logic [DATA_W:0]      dataout;

    modport master (
        output wr, datain0, datain1, rd,
        input  full, empty, dataout
    );

    modport slave (
        input  wr, datain0, datain1, rd,
        output full, empty, dataout
    );

endinterface

// File: rtl/fifo_merge_ms_stream_queue.sv
// -----------------------------------------------------------------------------
// stream_queue
//   Single-stream circular buffer with its own storage, head, tail and count.
//   Ports:
//   - clk_i, rst_i     : clock, synchronous active-high reset
//   - push_i           : write push_data_i at the tail (ignored while full)
//   - push_data_i      : payload to store
//   - pop_i            : advance the head (ignored while empty)
//   - head_data_o      : word at the head of the queue
//   - count_full_o     : queue holds DEPTH entries
//   - count_empty_o    : queue holds no entries
// -----------------------------------------------------------------------------
module stream_queue
    import fifo_ms_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              count_full_o,
    output logic              count_empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    // Flags come from the registered count only.
    assign count_full_o  = (count_q == FULL_CNT);
    assign count_empty_o = (count_q == '0);

    // A push into a full queue is dropped even if a pop happens in the same
    // cycle: the decision uses the count before the pop.
    assign push_ok = push_i & ~count_full_o;
    assign pop_ok  = pop_i & ~count_empty_o;

    assign head_data_o = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop_ok) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fifo_merge_ms.sv
// -----------------------------------------------------------------------------
// fifo_merge_ms
//   Two-stream merging FIFO. Each stream is buffered in its own queue; a
//   round-robin arbiter pops one word per accepted read and registers it as
//   {stream_id, payload} on dataout.
//   Ports:
//   - ck   : clock (rising edge)
//   - rst  : synchronous active-high reset
//   - bus  : fifo_merge_ms_if slave modport (wr, datain0/1, full, rd, empty,
//            dataout)
// -----------------------------------------------------------------------------
module fifo_merge_ms
    import fifo_ms_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic           ck,
    input  logic           rst,
    fifo_merge_ms_if.slave bus
);

    logic [DATA_W-1:0]    push_data [N_STREAMS];
    logic [DATA_W-1:0]    head_data [N_STREAMS];
    logic [N_STREAMS-1:0] q_full;
    logic [N_STREAMS-1:0] q_empty;
    logic [N_STREAMS-1:0] pop;

    stream_id_t        last_grant_q, last_grant_d;
    stream_id_t        sel;
    logic              accept;
    logic [DATA_W:0]   dataout_q, dataout_d;

    assign push_data[0] = bus.datain0;
    assign push_data[1] = bus.datain1;

    for (genvar g = 0; g < N_STREAMS; g++) begin : g_queue
        stream_queue #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_queue (
            .clk_i         (ck),
            .rst_i         (rst),
            .push_i        (bus.wr[g]),
            .push_data_i   (push_data[g]),
            .pop_i         (pop[g]),
            .head_data_o   (head_data[g]),
            .count_full_o  (q_full[g]),
            .count_empty_o (q_empty[g])
        );
    end

    assign bus.full    = q_full;
    assign bus.empty   = &q_empty;
    assign bus.dataout = dataout_q;

    // Arbiter: a lone non-empty queue wins; with both non-empty the stream
    // that was not served last wins.
    always_comb begin
        accept       = bus.rd & ~bus.empty;
        sel          = ~last_grant_q;
        if (q_empty[0]) begin
            sel = stream_id_t'(1);
        end else if (q_empty[1]) begin
            sel = stream_id_t'(0);
        end
        pop          = '0;
        last_grant_d = last_grant_q;
        dataout_d    = dataout_q;
        if (accept) begin
            pop          = N_STREAMS'(1) << sel;
            last_grant_d = sel;
            dataout_d    = {sel, head_data[sel]};
        end
    end

    // last_grant resets to stream 1 so stream 0 wins the first contention.
    always_ff @(posedge ck) begin
        if (rst) begin
            last_grant_q <= stream_id_t'(1);
            dataout_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            dataout_q    <= dataout_d;
        end
    end

endmodule

// File: tb/tb_fifo_merge_ms.sv
module tb_fifo_merge_ms;
    import fifo_ms_pkg::*;

    logic ck;
    logic rst;

    fifo_merge_ms_if #(.DATA_W(7)) bus ();

    fifo_merge_ms #(.DATA_W(7), .DEPTH(4)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic       rst;
        logic [1:0] wr;
        logic [6:0] d0;
        logic [6:0] d1;
        logic       rd;
        logic [1:0] full;
        logic       empty;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic r, input logic [1:0] w,
                                input logic [6:0] a, input logic [6:0] b,
                                input logic rd_, input logic [1:0] f,
                                input logic e, input logic [7:0] o);
        vec_t v;
        v.rst = r; v.wr = w; v.d0 = a; v.d1 = b; v.rd = rd_;
        v.full = f; v.empty = e; v.dout = o;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] w,
                         input logic [6:0] a, input logic [6:0] b,
                         input logic rd_);
        rst         = r;
        bus.wr      = w;
        bus.datain0 = a;
        bus.datain1 = b;
        bus.rd      = rd_;
    endtask

    initial begin
        drive(1'b1, 2'b00, 7'd0, 7'd0, 1'b0);

        //   rst wr     d0     d1     rd  full   empty dout
        // reset state
        add(1, 2'b00, 7'd0,  7'd0,  0, 2'b00, 1, 8'h00);
        // overflow and order, stream 0
        add(0, 2'b01, 7'd1,  7'd0,  0, 2'b00, 0, 8'h00);
        add(0, 2'b01, 7'd2,  7'd0,  0, 2'b00, 0, 8'h00);
        add(0, 2'b01, 7'd3,  7'd0,  0, 2'b00, 0, 8'h00);
        add(0, 2'b01, 7'd4,  7'd0,  0, 2'b01, 0, 8'h00);
        add(0, 2'b01, 7'd5,  7'd0,  0, 2'b01, 0, 8'h00);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 0, 8'h01);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 0, 8'h02);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 0, 8'h03);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 1, 8'h04);
        // reset so stream 0 wins the first contention again
        add(1, 2'b00, 7'd0,  7'd0,  0, 2'b00, 1, 8'h00);
        // round-robin interleave
        add(0, 2'b11, 7'd1,  7'd9,  0, 2'b00, 0, 8'h00);
        add(0, 2'b11, 7'd2,  7'd10, 0, 2'b00, 0, 8'h00);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 0, 8'h01);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 0, 8'h89);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 0, 8'h02);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 1, 8'h8A);
        // read when empty
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 1, 8'h8A);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 1, 8'h8A);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 1, 8'h8A);
        // full stream 1 then simultaneous write + read
        add(0, 2'b10, 7'd0,  7'd20, 0, 2'b00, 0, 8'h8A);
        add(0, 2'b10, 7'd0,  7'd21, 0, 2'b00, 0, 8'h8A);
        add(0, 2'b10, 7'd0,  7'd22, 0, 2'b00, 0, 8'h8A);
        add(0, 2'b10, 7'd0,  7'd23, 0, 2'b10, 0, 8'h8A);
        add(0, 2'b10, 7'd0,  7'd24, 1, 2'b00, 0, 8'h94);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 0, 8'h95);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 0, 8'h96);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 1, 8'h97);
        // write into empty with concurrent rd: no bypass
        add(0, 2'b01, 7'd7,  7'd0,  1, 2'b00, 0, 8'h97);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 1, 8'h07);
        // reset mid-operation
        add(0, 2'b11, 7'd1,  7'd11, 0, 2'b00, 0, 8'h07);
        add(0, 2'b11, 7'd2,  7'd12, 0, 2'b00, 0, 8'h07);
        add(0, 2'b11, 7'd3,  7'd13, 0, 2'b00, 0, 8'h07);
        add(1, 2'b00, 7'd0,  7'd0,  0, 2'b00, 1, 8'h00);
        add(0, 2'b00, 7'd0,  7'd0,  1, 2'b00, 1, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].d0, vecs[i].d1, vecs[i].rd);
            @(posedge ck);
            #1;
            chk($sformatf("v%0d full", i),    32'(bus.full),    32'(vecs[i].full));
            chk($sformatf("v%0d empty", i),   32'(bus.empty),   32'(vecs[i].empty));
            chk($sformatf("v%0d dataout", i), 32'(bus.dataout), 32'(vecs[i].dout));
        end

        // Fill both queues to full, then hold rd: output must alternate
        // streams starting with stream 0 (last reset left last_grant = 1).
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b11, 7'(8'h10 + i), 7'(8'h20 + i), 1'b0);
            @(posedge ck);
            #1;
        end
        chk("both full", 32'(bus.full), 32'h3);
        chk("both full empty", 32'(bus.empty), 32'h0);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] exp_w;
            logic [7:0] got;
            drive(1'b0, 2'b00, 7'd0, 7'd0, 1'b1);
            @(posedge ck);
            #1;
            exp_w = (k % 2 == 0) ? 8'(8'h10 + k / 2) : 8'(8'h80 | (8'h20 + k / 2));
            got   = bus.dataout;
            chk($sformatf("alt%0d dataout", k), 32'(got), 32'(exp_w));
            chk($sformatf("alt%0d tag", k), 32'(got[TAG_BIT]), 32'(k % 2));
        end
        chk("alt end empty", 32'(bus.empty), 32'h1);
        chk("alt end full", 32'(bus.full), 32'h0);

        drive(1'b0, 2'b00, 7'd0, 7'd0, 1'b0);
        @(posedge ck);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
